// File: rtl/conv_channel_out_broadcaster_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_channel_out_broadcaster_if                                    |
// | Pixel-in / replay-out bundle of the channel-out broadcaster.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface conv_channel_out_broadcaster_if #(
   parameter int DATA_WIDTH            = 32,
   parameter int CNT_CHANNEL_OUT_WIDTH = 8
);
   logic                             valid_in;
   logic [DATA_WIDTH-1:0]            pxl_in;
   logic                             ready_in;
   logic [DATA_WIDTH-1:0]            pxl_out;
   logic                             valid_out;
   logic [CNT_CHANNEL_OUT_WIDTH-1:0] channel_out;
   logic                             last_out;

   modport master (
      output valid_in, pxl_in,
      input  ready_in, pxl_out, valid_out, channel_out, last_out
   );

   modport slave (
      input  valid_in, pxl_in,
      output ready_in, pxl_out, valid_out, channel_out, last_out
   );
endinterface
`default_nettype wire

// File: rtl/conv_channel_out_broadcaster.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_channel_out_broadcaster                                       |
// | Captures one feature map and replays it once per output channel.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module conv_channel_out_broadcaster #(
   parameter int DATA_WIDTH            = 32,
   parameter int IMAGE_SIZE            = 256,
   parameter int IMAGE_WIDTH           = 16,
   parameter int RATE                  = 1,
   parameter int CHANNEL_NUM_OUT       = 128,
   parameter int GAP_CYCLES            = IMAGE_WIDTH*RATE + RATE,
   parameter int POINTER_WIDTH         = $clog2(IMAGE_SIZE) + 1,
   parameter int CNT_CHANNEL_OUT_WIDTH = $clog2(CHANNEL_NUM_OUT) + 1
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   conv_channel_out_broadcaster_if.slave bus
);
   localparam int c_ADDR_WIDTH = $clog2(IMAGE_SIZE);
   localparam int c_GAP_WIDTH  = $clog2(GAP_CYCLES) + 1;

   localparam logic [1:0] c_LOAD   = 2'd0;
   localparam logic [1:0] c_REPLAY = 2'd1;
   localparam logic [1:0] c_GAP    = 2'd2;

   logic [1:0]                       r_state;
   logic [1:0]                       w_state_next;
   logic [POINTER_WIDTH-1:0]         r_wr_ptr;
   logic [POINTER_WIDTH-1:0]         r_rd_ptr;
   logic [CNT_CHANNEL_OUT_WIDTH-1:0] r_pass;
   logic [c_GAP_WIDTH-1:0]           r_gap_cnt;
   logic [DATA_WIDTH-1:0]            r_mem [IMAGE_SIZE];

   logic                             r_valid_out;
   logic [DATA_WIDTH-1:0]            r_pxl_out;
   logic [CNT_CHANNEL_OUT_WIDTH-1:0] r_channel_out;
   logic                             r_last_out;

   logic w_ready;
   logic w_read;
   logic w_accept;
   logic w_last_wr;
   logic w_last_rd;
   logic w_last_pass;
   logic w_gap_done;

   assign w_accept    = bus.valid_in & w_ready;
   assign w_last_wr   = (r_wr_ptr == POINTER_WIDTH'(IMAGE_SIZE - 1));
   assign w_last_rd   = (r_rd_ptr == POINTER_WIDTH'(IMAGE_SIZE - 1));
   assign w_last_pass = (r_pass == CNT_CHANNEL_OUT_WIDTH'(CHANNEL_NUM_OUT - 1));
   assign w_gap_done  = (r_gap_cnt == c_GAP_WIDTH'(GAP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_LOAD;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_LOAD:   if (w_accept && w_last_wr) w_state_next = c_REPLAY;
         c_REPLAY: if (w_last_rd) w_state_next = w_last_pass ? c_LOAD : c_GAP;
         c_GAP:    if (w_gap_done) w_state_next = c_REPLAY;
         default:  w_state_next = c_LOAD;
      endcase
   end

   always_comb begin
      w_ready = (r_state == c_LOAD);
      w_read  = (r_state == c_REPLAY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_pass    <= '0;
         r_gap_cnt <= '0;
      end else begin
         case (r_state)
            c_LOAD: begin
               if (w_accept) begin
                  if (w_last_wr) begin
                     r_wr_ptr <= '0;
                     r_rd_ptr <= '0;
                     r_pass   <= '0;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                  end
               end
            end
            c_REPLAY: begin
               r_gap_cnt <= '0;
               if (w_last_rd) begin
                  r_rd_ptr <= '0;
                  // Final pass leaves the counter at its maximum; the next load clears it.
                  if (!w_last_pass) r_pass <= r_pass + 1'b1;
               end else begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
            end
            c_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // Buffer contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wr_ptr[c_ADDR_WIDTH-1:0]] <= bus.pxl_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_out   <= 1'b0;
         r_pxl_out     <= '0;
         r_channel_out <= '0;
         r_last_out    <= 1'b0;
      end else begin
         r_valid_out   <= w_read;
         r_pxl_out     <= w_read ? r_mem[r_rd_ptr[c_ADDR_WIDTH-1:0]] : '0;
         r_channel_out <= w_read ? r_pass : '0;
         r_last_out    <= w_read & w_last_rd & w_last_pass;
      end
   end

   assign bus.ready_in    = w_ready;
   assign bus.valid_out   = r_valid_out;
   assign bus.pxl_out     = r_pxl_out;
   assign bus.channel_out = r_channel_out;
   assign bus.last_out    = r_last_out;
endmodule
`default_nettype wire

// File: tb/tb_conv_channel_out_broadcaster.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_conv_channel_out_broadcaster                                    |
// | Directed bench with a cycle-schedule reference model.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_conv_channel_out_broadcaster;
   localparam int DW   = 32;
   localparam int IS   = 4;
   localparam int IW   = 2;
   localparam int RT   = 1;
   localparam int CNO  = 3;
   localparam int G    = IW*RT + RT;
   localparam int CW   = $clog2(CNO) + 1;
   localparam int IS_B = 256;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   conv_channel_out_broadcaster_if #(.DATA_WIDTH(DW), .CNT_CHANNEL_OUT_WIDTH(CW)) a();
   conv_channel_out_broadcaster_if #(.DATA_WIDTH(DW), .CNT_CHANNEL_OUT_WIDTH(1))  b();

   conv_channel_out_broadcaster #(
      .DATA_WIDTH(DW), .IMAGE_SIZE(IS), .IMAGE_WIDTH(IW), .RATE(RT), .CHANNEL_NUM_OUT(CNO)
   ) dut_a (.clk(clk), .reset(reset), .bus(a));

   conv_channel_out_broadcaster #(
      .DATA_WIDTH(DW), .IMAGE_SIZE(IS_B), .IMAGE_WIDTH(16), .RATE(1), .CHANNEL_NUM_OUT(1)
   ) dut_b (.clk(clk), .reset(reset), .bus(b));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_t = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: on image completion, schedule every output by cycle number.
   logic [31:0] e_pxl [int];
   int          e_ch  [int];
   bit          e_last[int];
   logic [31:0] img [IS];
   int nbeat = 0;
   int busy_until = 0;

   always @(posedge clk) begin
      if (reset) begin
         for (int k = cyc + 1; k < cyc + 200; k++) begin
            if (e_pxl.exists(k)) begin
               e_pxl.delete(k); e_ch.delete(k); e_last.delete(k);
            end
         end
         nbeat = 0;
         busy_until = 0;
      end else if (a.valid_in && cyc >= busy_until) begin
         img[nbeat] = a.pxl_in;
         nbeat++;
         if (nbeat == IS) begin
            for (int p = 0; p < CNO; p++) begin
               for (int i = 0; i < IS; i++) begin
                  e_pxl[cyc + 2 + p*(IS+G) + i]  = img[i];
                  e_ch[cyc + 2 + p*(IS+G) + i]   = p;
                  e_last[cyc + 2 + p*(IS+G) + i] = (p == CNO-1) && (i == IS-1);
               end
            end
            busy_until = cyc + 2 + (CNO-1)*(IS+G) + IS - 1;
            nbeat = 0;
         end
      end
      cyc++;
   end

   bit chk_en = 1'b0;
   int n_valid = 0;
   int n_last = 0;
   logic [31:0] last_last_pxl = '0;

   always @(negedge clk) begin
      bit ev;
      if (chk_en) begin
         ev = e_pxl.exists(cyc);
         chk("ready_in", a.ready_in, cyc >= busy_until);
         chk("valid_out", a.valid_out, ev);
         if (ev) begin
            chk("pxl_out", a.pxl_out, e_pxl[cyc]);
            chk("channel_out", a.channel_out, e_ch[cyc]);
            chk("last_out", a.last_out, e_last[cyc]);
         end else begin
            chk("pxl_out_idle", a.pxl_out, 0);
            chk("last_out_idle", a.last_out, 0);
         end
         if (a.valid_out) n_valid++;
         if (a.last_out) begin
            n_last++;
            last_last_pxl = a.pxl_out;
         end
      end
   end

   task automatic send(input logic [31:0] d);
      int n = 0;
      a.valid_in = 1'b1;
      a.pxl_in   = d;
      while (!a.ready_in && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", n >= 100, 0);
      last_t = cyc;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (cyc < busy_until + 2 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n >= 300, 0);
   endtask

   initial begin
      int t1, t2, nv0, nl0, k, idx, first_at, gaps;
      logic [31:0] acc;
      a.valid_in = 1'b0; a.pxl_in = '0;
      b.valid_in = 1'b0; b.pxl_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid_out", a.valid_out, 0);
      chk("rst_pxl_out", a.pxl_out, 0);
      chk("rst_channel_out", a.channel_out, 0);
      chk("rst_last_out", a.last_out, 0);
      chk("rst_ready_in", a.ready_in, 1);
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // Basic replay
      nv0 = n_valid; nl0 = n_last;
      send(32'h3F800000); send(32'h40000000); send(32'h40400000); send(32'h40800000);
      t1 = last_t;
      a.valid_in = 1'b0;
      chk("s1_no_valid_at_T1", a.valid_out, 0);
      @(negedge clk);
      chk("s1_latency", cyc - t1, 2);
      chk("s1_first_valid", a.valid_out, 1);
      chk("s1_first_pxl", a.pxl_out, 32'h3F800000);
      chk("s1_first_ch", a.channel_out, 0);
      wait_idle();
      chk("s1_valid_count", n_valid - nv0, 12);
      chk("s1_last_count", n_last - nl0, 1);
      chk("s1_last_pxl", last_last_pxl, 32'h40800000);

      // Backpressure: hold valid with fresh values through the whole replay
      send(32'hA0000000); send(32'hA0000001); send(32'hA0000002); send(32'hA0000003);
      k = 0;
      a.pxl_in = 32'hB0000000;
      while (!a.ready_in && k < 100) begin
         @(negedge clk);
         k++;
         a.pxl_in = 32'hB0000000 + k;
      end
      chk("s2_not_ready_cycles", k, 18);
      chk("s2_last_with_ready", a.last_out, 1);
      acc = a.pxl_in;
      @(negedge clk);
      send(32'hC0000001); send(32'hC0000002); send(32'hC0000003);
      a.valid_in = 1'b0;
      @(negedge clk);
      chk("s2_new_first_pxl", a.pxl_out, acc);
      chk("s2_new_first_lit", a.pxl_out, 32'hB0000012);
      wait_idle();

      // Bursty input
      nv0 = n_valid;
      send(32'h3F800000); a.valid_in = 1'b0; @(negedge clk);
      send(32'h40000000); a.valid_in = 1'b0; @(negedge clk);
      send(32'h40400000); a.valid_in = 1'b0; @(negedge clk);
      send(32'h40800000); a.valid_in = 1'b0;
      t1 = last_t;
      @(negedge clk);
      chk("s3_latency", cyc - t1, 2);
      chk("s3_first_pxl", a.pxl_out, 32'h3F800000);
      wait_idle();
      chk("s3_valid_count", n_valid - nv0, 12);
      chk("s3_last_pxl", last_last_pxl, 32'h40800000);

      // Reset during pass 1
      send(32'hD0000000); send(32'hD0000001); send(32'hD0000002); send(32'hD0000003);
      t1 = last_t;
      a.valid_in = 1'b0;
      k = 0;
      while (cyc < t1 + 9 && k < 50) begin @(negedge clk); k++; end
      chk("s4_in_pass1", a.channel_out, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("s4_valid_out", a.valid_out, 0);
      chk("s4_pxl_out", a.pxl_out, 0);
      chk("s4_channel_out", a.channel_out, 0);
      chk("s4_last_out", a.last_out, 0);
      chk("s4_ready_in", a.ready_in, 1);
      reset = 1'b0;
      @(negedge clk);
      nv0 = n_valid;
      send(32'hE0000000); send(32'hE0000001); send(32'hE0000002); send(32'hE0000003);
      a.valid_in = 1'b0;
      wait_idle();
      chk("s4_valid_count", n_valid - nv0, 12);
      chk("s4_last_pxl", last_last_pxl, 32'hE0000003);

      // Back-to-back images
      nv0 = n_valid; nl0 = n_last;
      send(32'hF0000000); send(32'hF0000001); send(32'hF0000002); send(32'hF0000003);
      t1 = last_t;
      send(32'hF0000004); send(32'hF0000005); send(32'hF0000006); send(32'hF0000007);
      t2 = last_t;
      a.valid_in = 1'b0;
      chk("s5_second_load_start", t2 - t1, 22);
      @(negedge clk);
      chk("s5_second_first_pxl", a.pxl_out, 32'hF0000004);
      chk("s5_second_first_ch", a.channel_out, 0);
      wait_idle();
      chk("s5_valid_count", n_valid - nv0, 24);
      chk("s5_last_count", n_last - nl0, 2);
      chk("s5_last_pxl", last_last_pxl, 32'hF0000007);

      // Single pass, 256-pixel image on the second instance
      for (int i = 0; i < IS_B; i++) begin
         b.valid_in = 1'b1;
         b.pxl_in   = 32'h10000000 + i;
         chk("s6_ready_load", b.ready_in, 1);
         @(negedge clk);
      end
      b.valid_in = 1'b0;
      chk("s6_no_valid_at_T1", b.valid_out, 0);
      idx = 0; first_at = -1; gaps = 0;
      for (int j = 0; j < 300; j++) begin
         @(negedge clk);
         if (b.valid_out) begin
            if (first_at < 0) first_at = j;
            chk("s6_pxl", b.pxl_out, 32'h10000000 + idx);
            chk("s6_ch", b.channel_out, 0);
            chk("s6_last", b.last_out, idx == IS_B - 1);
            if (idx == IS_B - 1) chk("s6_ready_at_last", b.ready_in, 1);
            idx++;
         end else if (idx > 0 && idx < IS_B) begin
            gaps++;
         end
      end
      chk("s6_count", idx, IS_B);
      chk("s6_latency", first_at, 0);
      chk("s6_gaps", gaps, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
